// File: rtl/io_port_responder.sv
// io_port_responder: I/O-bus peripheral for the RAT CPU. Holds LED and
// seven-segment registers, reads synchronized switches, and debounces an
// external event into a maskable, software-cleared interrupt.
// Ports:
//   CLK, RESET_N         clock, async active-low reset
//   PORT_ID, OUT_PORT    CPU address / write data
//   IO_STRB              one-cycle write strobe
//   IN_PORT              combinational read data
//   SWITCHES, EVENT      asynchronous board inputs
//   LEDS, SSEG_DATA      output registers
//   INTR                 interrupt request (pending & mask)
module io_port_responder #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [7:0] ID_SWITCHES     = 8'h20,
  parameter logic [7:0] ID_INT_CTRL     = 8'h30,
  parameter logic [7:0] ID_EVT_COUNT    = 8'h31,
  parameter logic [7:0] ID_LEDS         = 8'h40,
  parameter logic [7:0] ID_SSEG         = 8'h81
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  input  logic [7:0] SWITCHES,
  input  logic       EVENT,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_DATA,
  output logic       INTR
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  localparam logic [15:0] CNT_LAST =
    16'(DEBOUNCE_CYCLES - 1);

  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic        ev_meta;
  logic        s;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        accept;

  logic        mask;
  logic        pending;
  logic [7:0]  evt_cnt;
  logic [7:0]  leds_q;
  logic [7:0]  sseg_q;

  logic        wr_leds;
  logic        wr_sseg;
  logic        wr_ctrl;
  logic        clr;

  logic        rd_sw;
  logic        rd_ctrl;
  logic        rd_cnt;
  logic [7:0]  rd_data;

  // Two-flop synchronizers for both async inputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_meta <= '0;
      sw_sync <= '0;
      ev_meta <= 1'b0;
      s       <= 1'b0;
    end else begin
      sw_meta <= SWITCHES;
      sw_sync <= sw_meta;
      ev_meta <= EVENT;
      s       <= ev_meta;
    end
  end

  // Press and release each need DEBOUNCE_CYCLES
  // stable samples; accept fires on the press only.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s) begin
          state_nxt = ST_DEB;
          cnt_nxt   = '0;
        end
      end
      ST_DEB: begin
        if (!s) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HELD;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_nxt = ST_REL;
          cnt_nxt   = '0;
        end
      end
      ST_REL: begin
        if (s) begin
          state_nxt = ST_HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign wr_leds = IO_STRB && (PORT_ID == ID_LEDS);
  assign wr_sseg = IO_STRB && (PORT_ID == ID_SSEG);
  assign wr_ctrl = IO_STRB && (PORT_ID == ID_INT_CTRL);
  assign clr     = wr_ctrl && OUT_PORT[1];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      leds_q <= '0;
      sseg_q <= '0;
      mask   <= 1'b0;
    end else begin
      if (wr_leds) leds_q <= OUT_PORT;
      if (wr_sseg) sseg_q <= OUT_PORT;
      if (wr_ctrl) mask   <= OUT_PORT[0];
    end
  end

  // A new event outranks a same-edge software clear
  // so no press is ever lost.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending <= 1'b0;
      evt_cnt <= '0;
    end else begin
      if (accept) begin
        pending <= 1'b1;
        evt_cnt <= evt_cnt + 8'd1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

  assign rd_sw   = (PORT_ID == ID_SWITCHES);
  assign rd_ctrl = (PORT_ID == ID_INT_CTRL);
  assign rd_cnt  = (PORT_ID == ID_EVT_COUNT);

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      rd_sw:   rd_data = sw_sync;
      rd_ctrl: rd_data = {6'b0, pending, mask};
      rd_cnt:  rd_data = evt_cnt;
      default: rd_data = '0;
    endcase
  end

  assign IN_PORT   = rd_data;
  assign LEDS      = leds_q;
  assign SSEG_DATA = sseg_q;
  assign INTR      = pending & mask;

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: scoreboard bench for io_port_responder
// with DEBOUNCE_CYCLES = 4.
module tb_io_port_responder;

  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] PORT_ID = '0;
  logic [7:0] OUT_PORT = '0;
  logic       IO_STRB = 1'b0;
  logic [7:0] SWITCHES = '0;
  logic       EVENT = 1'b0;
  logic [7:0] IN_PORT;
  logic [7:0] LEDS;
  logic [7:0] SSEG_DATA;
  logic       INTR;

  int total = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  logic [7:0] model_cnt = '0;

  io_port_responder #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .IN_PORT(IN_PORT),
    .SWITCHES(SWITCHES), .EVENT(EVENT),
    .LEDS(LEDS), .SSEG_DATA(SSEG_DATA),
    .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [7:0] d);
    PORT_ID = a; OUT_PORT = d; IO_STRB = 1'b1;
    tick();
    IO_STRB = 1'b0;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; IO_STRB = 1'b0; EVENT = 1'b0;
    #3;
    PORT_ID = 8'h30; #1;
    exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL rst_ctrl got %h exp %h", IN_PORT, e);
    else passed++;
    PORT_ID = 8'h31; #1;
    exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL rst_evtcnt got %h exp %h", IN_PORT, e);
    else passed++;
    PORT_ID = 8'h40; #1;
    exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL rst_rd40 got %h exp %h", IN_PORT, e);
    else passed++;
    exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
    if ({LEDS ^ SSEG_DATA, 7'b0, INTR} !== {e, 8'h00} || LEDS !== e)
      $display("FAIL rst_outs got %h/%h/%b exp 00/00/0", LEDS, SSEG_DATA, INTR);
    else passed++;
    tick(2);
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_out_regs;
    exp_q.push_back(8'hA5);
    wr(8'h40, 8'hA5);
    e = exp_q.pop_front(); total++;
    if (LEDS !== e) $display("FAIL leds_wr got %h exp %h", LEDS, e);
    else passed++;
    exp_q.push_back(8'hA5);
    PORT_ID = 8'h40; OUT_PORT = 8'h5A; IO_STRB = 1'b0;
    tick();
    e = exp_q.pop_front(); total++;
    if (LEDS !== e) $display("FAIL leds_nostrb got %h exp %h", LEDS, e);
    else passed++;
    exp_q.push_back(8'h3C);
    wr(8'h81, 8'h3C);
    e = exp_q.pop_front(); total++;
    if (SSEG_DATA !== e) $display("FAIL sseg_wr got %h exp %h", SSEG_DATA, e);
    else passed++;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h00);
    wr(8'h99, 8'hFF);
    e = exp_q.pop_front(); total++;
    if (LEDS !== e) $display("FAIL unmapped_leds got %h exp %h", LEDS, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (SSEG_DATA !== e) $display("FAIL unmapped_sseg got %h exp %h", SSEG_DATA, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL unmapped_rd got %h exp %h", IN_PORT, e);
    else passed++;
    exp_q.push_back(8'h00);
    wr(8'h31, 8'hFF);
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL ro_evtcnt got %h exp %h", IN_PORT, e);
    else passed++;
    PORT_ID = 8'h81; #1;
    exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL wo_rd81 got %h exp %h", IN_PORT, e);
    else passed++;
  endtask

  task automatic test_switches;
    SWITCHES = 8'h6B; PORT_ID = 8'h20;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h6B);
    tick();
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL sw_1edge got %h exp %h", IN_PORT, e);
    else passed++;
    tick();
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL sw_2edge got %h exp %h", IN_PORT, e);
    else passed++;
  endtask

  task automatic test_debounce;
    PORT_ID = 8'h30;
    EVENT = 1'b1; tick(3); EVENT = 1'b0; tick(8);
    exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL glitch_pend got %h exp %h", IN_PORT, e);
    else passed++;
    EVENT = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    tick(D + 2);
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL deb_early got %h exp %h", IN_PORT, e);
    else passed++;
    tick();
    model_cnt = model_cnt + 8'd1;
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL deb_accept got %h exp %h", IN_PORT, e);
    else passed++;
    exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
    if ({7'b0, INTR} !== e) $display("FAIL masked_intr got %b exp %h", INTR, e);
    else passed++;
    PORT_ID = 8'h31; #1;
    exp_q.push_back(model_cnt); e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL deb_cnt got %h exp %h", IN_PORT, e);
    else passed++;
    exp_q.push_back(model_cnt);
    tick(20);
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL hold_cnt got %h exp %h", IN_PORT, e);
    else passed++;
    EVENT = 1'b0; tick(10);
  endtask

  task automatic test_intr_flow;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    wr(8'h30, 8'h01);
    e = exp_q.pop_front(); total++;
    if ({7'b0, INTR} !== e) $display("FAIL unmask_intr got %b exp %h", INTR, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL unmask_rd got %h exp %h", IN_PORT, e);
    else passed++;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    wr(8'h30, 8'h03);
    e = exp_q.pop_front(); total++;
    if ({7'b0, INTR} !== e) $display("FAIL clr_intr got %b exp %h", INTR, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL clr_rd got %h exp %h", IN_PORT, e);
    else passed++;
  endtask

  task automatic test_collision;
    PORT_ID = 8'h30; EVENT = 1'b1;
    tick(D + 2);
    model_cnt = model_cnt + 8'd1;
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h01);
    OUT_PORT = 8'h03; IO_STRB = 1'b1;
    tick();
    IO_STRB = 1'b0;
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL coll_pend got %h exp %h", IN_PORT, e);
    else passed++;
    e = exp_q.pop_front(); total++;
    if ({7'b0, INTR} !== e) $display("FAIL coll_intr got %b exp %h", INTR, e);
    else passed++;
    PORT_ID = 8'h31; #1;
    exp_q.push_back(model_cnt); e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL coll_cnt got %h exp %h", IN_PORT, e);
    else passed++;
    EVENT = 1'b0; tick(10);
    exp_q.push_back(8'h01);
    wr(8'h30, 8'h03);
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL coll_clr got %h exp %h", IN_PORT, e);
    else passed++;
  endtask

  task automatic test_release_bounce;
    PORT_ID = 8'h31; EVENT = 1'b1;
    tick(D + 4);
    model_cnt = model_cnt + 8'd1;
    for (int i = 0; i < 3; i++) begin
      EVENT = 1'b0; tick(2);
      EVENT = 1'b1; tick(2);
    end
    EVENT = 1'b0; tick(10);
    exp_q.push_back(model_cnt); e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL bounce_cnt got %h exp %h", IN_PORT, e);
    else passed++;
    exp_q.push_back(8'h00);
    wr(8'h30, 8'h03);
    e = exp_q.pop_front(); total++;
    if ({7'b0, INTR} !== e) $display("FAIL bounce_clr got %b exp %h", INTR, e);
    else passed++;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 256; i++) begin
      EVENT = 1'b1; tick(D + 4);
      EVENT = 1'b0; tick(D + 4);
      model_cnt = model_cnt + 8'd1;
      exp_q.push_back(model_cnt);
      PORT_ID = 8'h31; #1;
      e = exp_q.pop_front(); total++;
      if (IN_PORT !== e) $display("FAIL wrap_cnt%0d got %h exp %h", i, IN_PORT, e);
      else passed++;
    end
    wr(8'h30, 8'h03);
  endtask

  task automatic test_reset_mid_debounce;
    EVENT = 1'b1;
    tick(5);
    RESET_N = 1'b0; #1;
    PORT_ID = 8'h31; #1;
    exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL mid_rst_cnt got %h exp %h", IN_PORT, e);
    else passed++;
    PORT_ID = 8'h30; #1;
    exp_q.push_back(8'h00); e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL mid_rst_ctrl got %h exp %h", IN_PORT, e);
    else passed++;
    tick();
    RESET_N = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    tick(D + 2);
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL mid_rst_early got %h exp %h", IN_PORT, e);
    else passed++;
    tick();
    e = exp_q.pop_front(); total++;
    if (IN_PORT !== e) $display("FAIL mid_rst_restart got %h exp %h", IN_PORT, e);
    else passed++;
    EVENT = 1'b0;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_out_regs();
    test_switches();
    test_debounce();
    test_intr_flow();
    test_collision();
    test_release_bounce();
    test_wrap();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/io_port_responder.md
# io_port_responder

Peripheral-side responder for the RAT CPU I/O bus and interrupt line. Latches OUT writes qualified by `IO_STRB` into output registers, returns read data on `IN_PORT` for IN instructions, and produces the `INTR` request the control unit samples. A debounced external event source sets a pending flag; software masks and clears that flag through I/O ports. Sits between the CPU top level and board I/O (switches, LEDs, button).

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required to accept a press or a release. Range 2..65535.
- `ID_SWITCHES`, 8'h20: read-only port, synchronized switches.
- `ID_INT_CTRL`, 8'h30: read/write interrupt control and status port.
- `ID_EVT_COUNT`, 8'h31: read-only port, accepted-event count.
- `ID_LEDS`, 8'h40: write-only LED register.
- `ID_SSEG`, 8'h81: write-only seven-segment data register.

Ports:
- `CLK` in 1: single system clock, rising-edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `PORT_ID` in 8: I/O address from the CPU.
- `OUT_PORT` in 8: write data from the CPU.
- `IO_STRB` in 1: one-cycle write strobe driven by the control unit on OUT.
- `IN_PORT` out 8: combinational read data selected by `PORT_ID`.
- `SWITCHES` in 8: asynchronous board switches.
- `EVENT` in 1: asynchronous button or event input, active-high.
- `LEDS` out 8: LED register.
- `SSEG_DATA` out 8: seven-segment register.
- `INTR` out 1: interrupt request to the control unit. Equals `pending & mask`.

## Operation
- **Synchronizers.** `SWITCHES` and `EVENT` each pass through a 2-flop synchronizer. The synchronized `EVENT` is called `s`.
- **Writes.** A register updates only on an edge where `IO_STRB`=1 and `PORT_ID` matches its ID. Writes to unmapped or read-only IDs are ignored.
  - `ID_LEDS` and `ID_SSEG` load `OUT_PORT`.
  - `ID_INT_CTRL`: bit0 loads `mask`. If bit1=1, `pending` is cleared (write-1-to-clear). Other bits are ignored.
- **Reads** (combinational, independent of `IO_STRB`):
  - `ID_SWITCHES` returns the synchronized switches.
  - `ID_INT_CTRL` returns {6'b0, `pending`, `mask`}.
  - `ID_EVT_COUNT` returns `evt_cnt`.
  - Write-only and unmapped IDs return 8'h00.
- **Event FSM** (16-bit counter `cnt`):
  - IDLE: `s`=1 → DEBOUNCE, `cnt`=0.
  - DEBOUNCE: `s`=0 → IDLE. `s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → HELD and assert one-cycle `accept`. Otherwise `cnt`++.
  - HELD: `s`=0 → RELEASE, `cnt`=0.
  - RELEASE: `s`=1 → HELD. `s`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → IDLE. Otherwise `cnt`++.
- **On `accept`:** `pending`←1, and `evt_cnt`←`evt_cnt`+1 mod 256 (8'hFF wraps to 8'h00).
- **Simultaneous `accept` and clear write:** set wins, `pending` stays 1. `evt_cnt` still increments.
- **Masking:** `mask`=0 does not block `pending` or `evt_cnt`. When `mask` goes 1 with `pending`=1, `INTR` asserts immediately.

## Timing
- **Reset** (`RESET_N`=0, asynchronous, takes effect immediately):
  - FSM=IDLE, `cnt`=0, synchronizers=0.
  - `LEDS`=8'h00, `SSEG_DATA`=8'h00, `mask`=0, `pending`=0, `evt_cnt`=8'h00, `INTR`=0.
  - `IN_PORT` follows the reset register values.
- **Reset mid-debounce:** discards progress. No `accept` is produced after release of reset unless the full sequence restarts.
- **Write latency:** the new register value is visible at outputs and on readback after the strobed edge (1 cycle).
- **`INTR` latency after an ID_INT_CTRL write:** asserts or deasserts after the write edge.
- **`EVENT` latency:** with `EVENT` high before edge 1 and held, `s`=1 after edge 2, DEBOUNCE is entered at edge 3, and `accept` occurs at edge `DEBOUNCE_CYCLES`+3. `pending` (and `INTR` if masked-in) is high after that edge.
- **Glitch rejection:** a high pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no `accept`.
- **Holding:** holding `EVENT` high produces exactly one `accept`.
- **Release bounce:** lows shorter than `DEBOUNCE_CYCLES` during RELEASE return to HELD with no new `accept`.
- **`INTR` hold:** stays high until cleared by software. It is level, not a pulse.

## Test plan
- **Reset values:** reset, then read 0x30, 0x31, 0x40 → all 8'h00, `INTR`=0. Assert `RESET_N`=0 mid-DEBOUNCE → no `accept` follows.
- **Output registers:** OUT 0x40 ← 8'hA5 with `IO_STRB` → `LEDS`=8'hA5 next cycle. Same bus cycle with `IO_STRB`=0 → no change. Write to 0x99 → no register changes, read returns 8'h00.
- **Debounced event** (`DEBOUNCE_CYCLES`=4): `EVENT` high for 3 cycles → no `accept`. Then high steadily → `pending`=1 after edge 7 from rise. Read 0x31 → 8'h01. `INTR` stays 0 while `mask`=0.
- **Interrupt flow:** write 0x30 ← 8'h01 → `INTR`=1. Write 0x30 ← 8'h03 → `pending`=0, `INTR`=0, `mask` stays 1.
- **Collision:** clear write lands on the same edge as `accept` → `pending`=1, `evt_cnt` incremented.
- **Wrap and release bounce:** 256 clean presses → `evt_cnt` 8'hFF→8'h00. Release bounce of 2-cycle lows → no extra count.
